gate_identifier: RTL

GATE_IDENTIFIER -- requirements
Module: gate_identifier

---
 rtl/gate_identifier_if.sv | 30 +++
 rtl/gate_identifier.sv | 133 +++++++++++++
 2 files changed

// File: rtl/gate_identifier_if.sv
// Bundle between the gate identifier and the gate-select mux under test.
//   start   : request one identification sweep
//   LED_IN  : 1-bit mux response (asynchronous to clk)
//   PROBE0/1: stimulus to the mux SW0/SW1 inputs
//   busy    : sweep in progress
//   TT      : captured truth table, TT[i] = response to {PROBE1,PROBE0}=i
//   OP      : recovered mux select code
//   valid   : OP/TT/unknown hold the last completed sweep
//   unknown : TT matched no legal code
interface gate_identifier_if;
    logic       start;
    logic       LED_IN;
    logic       PROBE0;
    logic       PROBE1;
    logic       busy;
    logic [3:0] TT;
    logic [2:0] OP;
    logic       valid;
    logic       unknown;

    modport master (
        output start, LED_IN,
        input  PROBE0, PROBE1, busy, TT, OP, valid, unknown
    );

    modport slave (
        input  start, LED_IN,
        output PROBE0, PROBE1, busy, TT, OP, valid, unknown
    );
endinterface

// File: rtl/gate_identifier.sv
// Identifies which 2-input gate a select mux is configured as by driving all
// four probe vectors, capturing the response truth table and decoding it.
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset
//   gi  : slave side of gate_identifier_if (start/LED_IN in, probes/result out)
// SETTLE (3..15) is the number of cycles each probe vector is held; the lower
// bound leaves room for the two-flop synchronizer latency before sampling.
module gate_identifier #(
    parameter int unsigned SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    gate_identifier_if.slave  gi
);

    localparam int unsigned       CNT_W    = 4;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        DECODE = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sync1;
    logic             r_sync2;
    logic [3:0]       r_tt;
    logic [2:0]       r_op;
    logic             r_valid;
    logic             r_unknown;
    logic             r_busy;
    logic [1:0]       r_probe;

    logic [2:0]       w_op;
    logic             w_unknown;

    // Two-flop synchronizer for the asynchronous mux response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= gi.LED_IN;
            r_sync2 <= r_sync1;
        end
    end

    // Truth table to select-code lookup
    always_comb begin
        w_op      = 3'd0;
        w_unknown = 1'b0;
        case (r_tt)
            4'b0101: w_op = 3'd0;   // NOT
            4'b1010: w_op = 3'd1;   // BUF
            4'b1001: w_op = 3'd2;   // XNOR
            4'b0110: w_op = 3'd3;   // XOR
            4'b1110: w_op = 3'd4;   // OR
            4'b0001: w_op = 3'd5;   // NOR
            4'b1000: w_op = 3'd6;   // AND
            4'b0111: w_op = 3'd7;   // NAND
            default: w_unknown = 1'b1;
        endcase
    end

    // Sweep FSM; probe register tracks vec so it is 00 outside DRIVE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_vec     <= 2'd0;
            r_cnt     <= '0;
            r_tt      <= 4'd0;
            r_op      <= 3'd0;
            r_valid   <= 1'b0;
            r_unknown <= 1'b0;
            r_busy    <= 1'b0;
            r_probe   <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (gi.start) begin
                        r_state   <= DRIVE;
                        r_vec     <= 2'd0;
                        r_cnt     <= '0;
                        r_tt      <= 4'd0;
                        r_valid   <= 1'b0;
                        r_unknown <= 1'b0;
                        r_busy    <= 1'b1;
                        r_probe   <= 2'd0;
                    end
                end
                DRIVE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt       <= '0;
                        r_tt[r_vec] <= r_sync2;
                        if (r_vec == 2'd3) begin
                            r_state <= DECODE;
                            r_probe <= 2'd0;
                        end else begin
                            r_vec   <= r_vec + 2'd1;
                            r_probe <= r_vec + 2'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DECODE: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_op      <= w_op;
                    r_unknown <= w_unknown;
                    r_valid   <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_probe <= 2'd0;
                end
            endcase
        end
    end

    assign gi.PROBE0  = r_probe[0];
    assign gi.PROBE1  = r_probe[1];
    assign gi.busy    = r_busy;
    assign gi.TT      = r_tt;
    assign gi.OP      = r_op;
    assign gi.valid   = r_valid;
    assign gi.unknown = r_unknown;

endmodule
